// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and constants for the multdiv unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage : multdiv_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration (radix 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_quo_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_quo_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // rem < divisor always holds, so a non-negative trial fits in WIDTH bits
    // and a negative one always sets the top bit of the (WIDTH+1)-bit result.
    assign w_shifted = {i_rem, i_quo_msb};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    assign o_quo_bit = ~w_trial[WIDTH];
    assign o_rem     = o_quo_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule : div_step

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Sequential signed restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic             r_zero;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_quo_bit;
    logic [WIDTH-1:0] w_quo_signed;
    logic             w_last_step;
    logic             w_rdy_set;

    // Magnitudes are taken as unsigned, so negating MIN yields 2^(WIDTH-1) exactly.
    assign w_b_zero     = (data_operandB == '0);
    assign w_abs_a      = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_abs_b      = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign w_quo_signed = r_sign ? (~r_quo + 1'b1) : r_quo;
    assign w_last_step  = (r_cnt == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo_bit (w_quo_bit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero-divide completes on the edge that leaves DONE, a normal one on the
    // FIX edge; both therefore pulse ready one edge after the result is known.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy_set   = 1'b0;
        case (r_state)
            ST_RUN:  if (w_last_step) w_state_nxt = ST_FIX;
            ST_FIX:  begin
                w_state_nxt = ST_DONE;
                w_rdy_set   = ~ctrl_DIV;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_rdy_set   = r_zero;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (ctrl_DIV) begin
            w_state_nxt = w_b_zero ? ST_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= w_rdy_set;
            if (w_rdy_set) begin
                r_exc    <= r_zero;
                r_result <= r_zero ? '0 : w_quo_signed;
            end
            if (ctrl_DIV) begin
                r_quo  <= w_abs_a;
                r_div  <= w_abs_b;
                r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_zero <= w_b_zero;
                r_rem  <= '0;
                r_cnt  <= '0;
            end else if (r_state == ST_RUN) begin
                r_rem <= w_rem_nxt;
                r_quo <= {r_quo[WIDTH-2:0], w_quo_bit};
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule : seq_divider

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_total = 0;
    int n_bad   = 0;

    seq_divider #(
        .WIDTH (32)
    ) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge, then scrambles operands to prove they are latched.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Edges counted from the start edge; lat = 0 means no ready within budget.
    task automatic wait_rdy(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_exc, input int exp_lat);
        int lat;
        start_div(a, b);
        wait_rdy(60, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, data_result, exp_q);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int lat;
        int early;
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("rst_res", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_div("p100_7",   32'd100,        32'd7,          32'd14,         1'b0, 33);
        do_div("n100_7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0, 33);
        do_div("p100_n7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0, 33);
        do_div("n100_n7",  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0, 33);
        do_div("p7_100",   32'd7,          32'd100,        32'd0,          1'b0, 33);
        do_div("div0",     32'd7,          32'd0,          32'd0,          1'b1, 1);
        do_div("p9_3",     32'd9,          32'd3,          32'd3,          1'b0, 33);
        do_div("min_m1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 33);
        do_div("min_1",    32'h80000000,   32'd1,          32'h80000000,   1'b0, 33);
        do_div("max_2",    32'h7FFFFFFF,   32'd2,          32'h3FFFFFFF,   1'b0, 33);

        // Back-to-back: the next start lands on the edge that leaves DONE.
        start_div(32'd100, 32'd7);
        wait_rdy(60, lat);
        check("b2b_first_lat", 32'(lat), 32'd33);
        start_div(32'hFFFFFF9C, 32'd7);
        check("b2b_pulse", {31'd0, data_resultRDY}, 32'd0);
        wait_rdy(60, lat);
        check("b2b_second_lat", 32'(lat), 32'd33);
        check("b2b_second_res", data_result, 32'hFFFFFFF2);
        @(posedge clock);
        #1;

        // Abort: restart at cycle 10; only the second operation may complete.
        start_div(32'd1000, 32'd3);
        early = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early++;
        end
        start_div(32'd50, 32'd5);
        if (data_resultRDY) early++;
        check("abort_early_rdy", 32'(early), 32'd0);
        wait_rdy(60, lat);
        check("abort_lat", 32'(lat), 32'd33);
        check("abort_res", data_result, 32'd10);
        @(posedge clock);
        #1;

        // Reset mid-operation: outputs clear without a clock and no ready follows.
        start_div(32'd1000, 32'd3);
        repeat (14) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_res", data_result, 32'd0);
        check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_rdy(45, lat);
        check("midrst_no_rdy", 32'(lat), 32'd0);
        do_div("after_rst", 32'd1000, 32'd3, 32'd333, 1'b0, 33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_seq_divider

`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Sequential signed integer divider paired with the combinational multiplier in the multdiv unit. It takes two's-complement operands on a start pulse and produces a truncated quotient through one restoring-division step per clock. It reports divide-by-zero through an exception flag. It uses the same operand/result/ready port scheme as the multiplier so the multdiv top level can mux the two.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  WIDTH  dividend, two's complement; sampled only on a start edge.
- data_operandB  input  WIDTH  divisor, two's complement; sampled only on a start edge.
- ctrl_DIV  input  1  start; sampled on every rising edge.
- data_result  output  WIDTH  quotient, registered.
- data_exception  output  1  divide-by-zero flag, registered; valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle completion pulse, registered.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Start: on an edge with ctrl_DIV=1, in any state:
  - latch |A| into the quotient/dividend shift register and |B| into the divisor register;
  - latch sign = A[WIDTH-1] ^ B[WIDTH-1]; clear the remainder and the counter;
  - if B==0, go to DONE with the zero flag set; otherwise go to RUN.
- RUN: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - Compute trial = rem_shifted − divisor, using a (WIDTH+1)-bit subtract.
  - If trial ≥ 0: rem = trial and quo[0] = 1. Otherwise keep the shifted rem and set quo[0] = 0.
  - Increment the counter. After the step where counter reaches WIDTH, go to FIX.
- FIX: register data_result = sign ? −quo : quo. Go to DONE.
- DONE: data_resultRDY=1 and data_exception = zero flag for exactly this one cycle. Next state is IDLE, unless ctrl_DIV=1, which starts a new operation.
- Divide by zero: data_result=0, data_exception=1.
- Arithmetic rules:
  - Magnitudes are unsigned WIDTH-bit, so |MIN| = 2^(WIDTH-1) is exact.
  - The quotient truncates toward zero. The remainder is internal only and is not output.
  - MIN / −1 wraps: result = MIN, data_exception = 0.
- Output hold rules:
  - data_result holds its last value until the next FIX or zero-divide DONE entry.
  - data_exception holds its last value until the next DONE entry.
- Restart: ctrl_DIV during RUN or FIX aborts the current operation and starts a new one. No data_resultRDY is issued for the aborted operation.

## Timing
- Reset (async assert, sync release): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0; all internal registers 0.
- Normal latency, with the start edge as edge 0:
  - RUN steps at edges 1..WIDTH;
  - FIX at edge WIDTH+1;
  - data_resultRDY is high between edges WIDTH+1 and WIDTH+2, i.e. 33 cycles after start for WIDTH=32.
- Divide-by-zero latency: data_resultRDY is high between edges 1 and 2.
- Back-to-back: ctrl_DIV on the edge that leaves DONE starts the next divide with no idle cycle.
- Reset asserted mid-operation: the operation is discarded immediately and no data_resultRDY is produced.
- The inputs data_operandA and data_operandB may change freely outside start edges.

## Structure
- Package multdiv_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE) as a 2-bit typedef;
  - the default WIDTH constant, shared with the multiplier.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, the incoming quotient MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Kept separate so a radix-4 (two-step) variant can be swapped in later.
- The sequential top level holds the FSM, the counter, the sign/abs logic and the output registers.

## Test plan
- 100 / 7 → data_resultRDY high exactly 33 cycles after start; result 14; exception 0.
- Sign combinations of 100 / 7 (−100/7, 100/−7, −100/−7) → −14 (0xFFFFFFF2), −14, 14 respectively; 7 / 100 → 0.
- 7 / 0 → data_resultRDY 1 cycle after start; result 0; exception 1. A following 9 / 3 → result 3 with exception 0.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 0. 0x80000000 / 1 → 0x80000000.
- Start 1000 / 3, then re-pulse ctrl_DIV with 50 / 5 at cycle 10 → only one data_resultRDY, 33 cycles after the second start, result 10.
- Assert reset_n=0 at cycle 15 of a divide → outputs go to 0 asynchronously; no data_resultRDY follows; the next divide completes normally.
